// File: rtl/onchip_ram_avalon_pipelined.sv
// Parametrised single-port on-chip RAM, Avalon-MM slave.
// Pipelined reads with readdatavalid, waitrequest and clear-on-reset sweep.
module onchip_ram_avalon_pipelined #(
  parameter int    DATA_W         = 32,
  parameter int    ADDR_W         = 10,
  parameter int    DEPTH          = 1024,
  parameter int    RD_LATENCY     = 1,
  parameter bit    CLEAR_ON_RESET = 1'b1,
  parameter string INIT_FILE      = ""
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                chipselect,
  input  logic [ADDR_W-1:0]   address,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                clken,
  output logic                waitrequest,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                init_done
);

  localparam int NB = DATA_W / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [IW-1:0]   LAST    = IW'(DEPTH - 1);

  // Preload images come from the memory-init flow, not from this logic.
  localparam bit unused_init_file = (INIT_FILE != "");

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam state_t RST_ST = CLEAR_ON_RESET ? CLEAR : READY;

  state_t            state_q, state_d;
  logic [IW-1:0]     clr_q, clr_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic          in_range;
  logic [IW-1:0] idx;
  logic          wr_acc;
  logic          rd_acc;
  logic          clr_we;

  assign waitrequest = ~reset_n | (state_q != READY) | ~clken;
  assign init_done   = reset_n & (state_q == READY);

  assign in_range = {1'b0, address} < DEPTH_L;
  assign idx      = address[IW-1:0];
  assign wr_acc   = chipselect & write & ~waitrequest;
  assign rd_acc   = chipselect & read & ~write & ~waitrequest;
  assign clr_we   = reset_n & (state_q == CLEAR) & clken;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_ST;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    unique case (state_q)
      CLEAR: begin
        if (clken) begin
          clr_d = clr_q + 1'b1;
          if (clr_q == LAST) begin
            state_d = READY;
            clr_d   = '0;
          end
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = RST_ST;
      end
    endcase
  end

  // Storage has no reset; zeroing is done by the sweep.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_q] <= '0;
    end else if (wr_acc && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (byteenable[b]) begin
          mem[idx][b*8 +: 8] <= writedata[b*8 +: 8];
        end
      end
    end
  end

  logic              v1_q;
  logic [DATA_W-1:0] d1_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else if (clken) begin
      v1_q <= rd_acc;
      if (rd_acc) begin
        d1_q <= in_range ? mem[idx] : '0;
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic              v2_q;
      logic [DATA_W-1:0] d2_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          v2_q <= 1'b0;
          d2_q <= '0;
        end else if (clken) begin
          v2_q <= v1_q;
          if (v1_q) begin
            d2_q <= d1_q;
          end
        end
      end

      assign readdatavalid = v2_q & clken;
      assign readdata      = d2_q;
    end else begin : g_lat1
      assign readdatavalid = v1_q & clken;
      assign readdata      = d1_q;
    end
  endgenerate

endmodule
